// File: rtl/md5_search_pkg.sv
// Shared types and widths for the MD5 pre-image search path.
// Exports: DIGEST_W, SEL_W (selector output width), state_t.
package md5_search_pkg;

    localparam int DIGEST_W = 128;
    // The target selector's dataOut feeds the search target directly.
    localparam int SEL_W = DIGEST_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/search_outstanding_ctr.sv
// Up/down counter of candidates issued to the MD5 pipe but not yet returned.
// Ports: i_clk, i_reset, i_inc (cand issued), i_dec (digest back), o_zero.
module search_outstanding_ctr #(
    parameter int LATENCY = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = $clog2(LATENCY + 2);

    logic [CW-1:0] r_count;

    // A decrement with nothing outstanding is dropped so a stray digest
    // after an abort cannot wrap the counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + 1'b1;
        end else if (!i_inc && i_dec && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/md5_search_ctrl.sv
// Brute-force MD5 pre-image search controller: streams candidates into an
// in-order MD5 pipe and reports the first candidate whose digest matches.
// Ports: i_clk, i_reset, i_start, i_target -> o_cand_out, o_cand_valid;
//        i_digest_in, i_digest_valid -> o_busy, o_found, o_found_value,
//        o_exhausted.
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               LATENCY     = 64,
    parameter logic [WIDTH-1:0] START_VALUE = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [DIGEST_W-1:0] i_target,
    output logic [WIDTH-1:0]    o_cand_out,
    output logic                o_cand_valid,
    input  logic [DIGEST_W-1:0] i_digest_in,
    input  logic                i_digest_valid,
    output logic                o_busy,
    output logic                o_found,
    output logic [WIDTH-1:0]    o_found_value,
    output logic                o_exhausted
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t              r_state;
    state_t              w_next;
    logic [DIGEST_W-1:0] r_target;
    logic [WIDTH-1:0]    r_cand;
    logic [WIDTH-1:0]    r_res;
    logic                r_found;
    logic [WIDTH-1:0]    r_found_value;
    logic                r_exhausted;
    logic                w_zero;
    logic                w_active;
    logic                w_start_ok;
    logic                w_match;
    logic                w_exhaust;

    assign w_active   = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_ok = i_start && w_zero &&
                        ((r_state == IDLE) || (r_state == DONE));
    // Digests landing in IDLE/DONE belong to an abandoned run.
    assign w_match    = w_active && i_digest_valid &&
                        (i_digest_in == r_target);
    assign w_exhaust  = (r_state == DRAIN) && i_digest_valid &&
                        (r_res == ALL_ONES) && !w_match;

    search_outstanding_ctr #(
        .LATENCY(LATENCY)
    ) u_outstanding (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_cand_valid),
        .i_dec   (i_digest_valid),
        .o_zero  (w_zero)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_start_ok) w_next = RUN;
            end
            RUN: begin
                if (w_match)                  w_next = DONE;
                else if (r_cand == ALL_ONES)  w_next = DRAIN;
            end
            DRAIN: begin
                if (w_match || w_exhaust) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_cand_valid = (r_state == RUN);
        o_busy       = w_active || !w_zero;
    end

    // Datapath: candidate issue, result tracking, sticky flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_target      <= '0;
            r_cand        <= '0;
            r_res         <= '0;
            r_found       <= 1'b0;
            r_found_value <= '0;
            r_exhausted   <= 1'b0;
        end else if (w_start_ok) begin
            r_target    <= i_target;
            r_cand      <= START_VALUE;
            r_res       <= START_VALUE;
            r_found     <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            if (r_state == RUN) begin
                r_cand <= r_cand + 1'b1;
            end
            // In-order pipe: r_res names the candidate of i_digest_in.
            if (w_active && i_digest_valid) begin
                r_res <= r_res + 1'b1;
            end
            if (w_match) begin
                r_found       <= 1'b1;
                r_found_value <= r_res;
            end
            if (w_exhaust) begin
                r_exhausted <= 1'b1;
            end
        end
    end

    assign o_cand_out    = r_cand;
    assign o_found       = r_found;
    assign o_found_value = r_found_value;
    assign o_exhausted   = r_exhausted;

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl with a stub MD5 pipe (digest = {4{cand}}, 5 cycles).
// Second instance covers a non-zero START_VALUE.
module tb_md5_search_ctrl;

    localparam int W   = 8;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         s1, s2;
    logic [127:0] t1, t2;
    logic [W-1:0] co1, co2;
    logic         cv1, cv2;
    logic [127:0] dig1, dig2;
    logic         dv1, dv2;
    logic         b1, b2;
    logic         f1, f2;
    logic [W-1:0] fv1, fv2;
    logic         ex1, ex2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    md5_search_ctrl #(
        .WIDTH(W), .LATENCY(LAT), .START_VALUE(8'h00)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(s1), .i_target(t1),
        .o_cand_out(co1), .o_cand_valid(cv1),
        .i_digest_in(dig1), .i_digest_valid(dv1),
        .o_busy(b1), .o_found(f1), .o_found_value(fv1),
        .o_exhausted(ex1)
    );

    md5_search_ctrl #(
        .WIDTH(W), .LATENCY(LAT), .START_VALUE(8'hFE)
    ) dut2 (
        .i_clk(clk), .i_reset(rst), .i_start(s2), .i_target(t2),
        .o_cand_out(co2), .o_cand_valid(cv2),
        .i_digest_in(dig2), .i_digest_valid(dv2),
        .o_busy(b2), .o_found(f2), .o_found_value(fv2),
        .o_exhausted(ex2)
    );

    // Stub MD5 pipes: LAT-stage shift registers
    logic [LAT-1:0]        pv1, pv2;
    logic [LAT-1:0][W-1:0] pc1, pc2;

    always_ff @(posedge clk) begin
        if (rst) begin
            pv1 <= '0; pc1 <= '0;
            pv2 <= '0; pc2 <= '0;
        end else begin
            pv1 <= {pv1[LAT-2:0], cv1};
            pc1 <= {pc1[LAT-2:0], co1};
            pv2 <= {pv2[LAT-2:0], cv2};
            pc2 <= {pc2[LAT-2:0], co2};
        end
    end

    assign dv1  = pv1[LAT-1];
    assign dig1 = {4{24'h0, pc1[LAT-1]}};
    assign dv2  = pv2[LAT-1];
    assign dig2 = {4{24'h0, pc2[LAT-1]}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start1(input logic [127:0] tgt);
        t1 = tgt;
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
    endtask

    // Waits for o_found/o_exhausted on dut; hit reports whether the digest
    // seen in the previous cycle matched exp_tgt.
    task automatic wait_done1(input logic [127:0] exp_tgt,
                              output logic hit);
        int n;
        n   = 0;
        hit = 1'b0;
        while (!(f1 || ex1) && n < 400) begin
            hit = dv1 && (dig1 == exp_tgt);
            tick();
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_done timeout: got %0d cycles required <400", n);
        end
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        while (b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (b1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %0b required 0", b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (co1 !== 8'h00) begin
            errors++; $display("FAIL rst_cand_out: got %0h required 0", co1);
        end
        checks++;
        if (cv1 !== 1'b0) begin
            errors++; $display("FAIL rst_cand_valid: got %0b required 0", cv1);
        end
        checks++;
        if (b1 !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %0b required 0", b1);
        end
        checks++;
        if (f1 !== 1'b0) begin
            errors++; $display("FAIL rst_found: got %0b required 0", f1);
        end
        checks++;
        if (fv1 !== 8'h00) begin
            errors++; $display("FAIL rst_found_value: got %0h required 0", fv1);
        end
        checks++;
        if (ex1 !== 1'b0) begin
            errors++; $display("FAIL rst_exhausted: got %0b required 0", ex1);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_match_mid();
        logic hit;
        pulse_start1({4{32'h0000002A}});
        checks++;
        if (cv1 !== 1'b1 || co1 !== 8'h00) begin
            errors++;
            $display("FAIL first_cand: got v=%0b c=%0h required v=1 c=0",
                     cv1, co1);
        end
        wait_done1({4{32'h0000002A}}, hit);
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL match_timing: got %0b required 1", hit);
        end
        checks++;
        if (fv1 !== 8'h2A) begin
            errors++; $display("FAIL match_2a_value: got %0h required 2a", fv1);
        end
        checks++;
        if (ex1 !== 1'b0) begin
            errors++; $display("FAIL match_2a_exh: got %0b required 0", ex1);
        end
        checks++;
        if (cv1 !== 1'b0 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL match_2a_drain: got v=%0b busy=%0b required v=0 busy=1",
                     cv1, b1);
        end
        wait_idle1();
    endtask

    task automatic test_exhaust();
        logic hit;
        int   cnt;
        int   n;
        pulse_start1(128'h1);
        cnt = 0;
        n   = 0;
        while (!(f1 || ex1) && n < 400) begin
            if (cv1) cnt++;
            tick();
            n++;
        end
        hit = (n < 400);
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL exh_timeout: got %0d cycles required <400", n);
        end
        checks++;
        if (cnt !== 256) begin
            errors++; $display("FAIL exh_cand_count: got %0d required 256", cnt);
        end
        checks++;
        if (ex1 !== 1'b1 || f1 !== 1'b0) begin
            errors++;
            $display("FAIL exh_flags: got ex=%0b f=%0b required ex=1 f=0",
                     ex1, f1);
        end
        wait_idle1();
    endtask

    task automatic test_last_match();
        logic hit;
        pulse_start1({4{32'h000000FF}});
        wait_done1({4{32'h000000FF}}, hit);
        checks++;
        if (f1 !== 1'b1 || fv1 !== 8'hFF) begin
            errors++;
            $display("FAIL last_match: got f=%0b v=%0h required f=1 v=ff",
                     f1, fv1);
        end
        checks++;
        if (ex1 !== 1'b0) begin
            errors++; $display("FAIL last_match_exh: got %0b required 0", ex1);
        end
        wait_idle1();
    endtask

    task automatic test_start_ignored();
        logic hit;
        pulse_start1({4{32'h00000010}});
        repeat (3) tick();
        pulse_start1({4{32'h00000005}});
        wait_done1({4{32'h00000010}}, hit);
        checks++;
        if (fv1 !== 8'h10) begin
            errors++; $display("FAIL ign_run_start: got %0h required 10", fv1);
        end
        // DONE with digests still in flight: start must not take
        pulse_start1({4{32'h00000005}});
        checks++;
        if (cv1 !== 1'b0 || f1 !== 1'b1) begin
            errors++;
            $display("FAIL ign_drain_start: got v=%0b f=%0b required v=0 f=1",
                     cv1, f1);
        end
        wait_idle1();
        pulse_start1({4{32'h00000005}});
        wait_done1({4{32'h00000005}}, hit);
        checks++;
        if (fv1 !== 8'h05) begin
            errors++; $display("FAIL restart_05: got %0h required 05", fv1);
        end
        wait_idle1();
    endtask

    task automatic test_reset_mid_run();
        logic hit;
        pulse_start1({4{32'h00000080}});
        repeat (20) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({co1, cv1, b1, f1, fv1, ex1} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got c=%0h v=%0b b=%0b f=%0b fv=%0h ex=%0b required all 0",
                     co1, cv1, b1, f1, fv1, ex1);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cv1 !== 1'b0 || b1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: got v=%0b b=%0b required 0 0", cv1, b1);
        end
        pulse_start1({4{32'h00000033}});
        wait_done1({4{32'h00000033}}, hit);
        checks++;
        if (f1 !== 1'b1 || fv1 !== 8'h33) begin
            errors++;
            $display("FAIL midrst_restart: got f=%0b v=%0h required f=1 v=33",
                     f1, fv1);
        end
        wait_idle1();
    endtask

    task automatic test_start_value();
        int n;
        t2 = {4{32'h000000FE}};
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        // FF would match if the target were not latched
        t2 = {4{32'h000000FF}};
        checks++;
        if (cv2 !== 1'b1 || co2 !== 8'hFE) begin
            errors++;
            $display("FAIL sv_first_cand: got v=%0b c=%0h required v=1 c=fe",
                     cv2, co2);
        end
        n = 0;
        while (!(f2 || ex2) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (f2 !== 1'b1 || fv2 !== 8'hFE) begin
            errors++;
            $display("FAIL sv_found: got f=%0b v=%0h required f=1 v=fe",
                     f2, fv2);
        end
        checks++;
        if (ex2 !== 1'b0) begin
            errors++; $display("FAIL sv_exh: got %0b required 0", ex2);
        end
    endtask

    initial begin
        rst = 1'b1;
        s1  = 1'b0;
        s2  = 1'b0;
        t1  = '0;
        t2  = '0;
        test_reset();
        test_match_mid();
        test_exhaust();
        test_last_match();
        test_start_ignored();
        test_reset_mid_run();
        test_start_value();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
